gray_stream_decoder: RTL and testbench
======================================

GRAY_STREAM_DECODER -- requirements
Module: gray_stream_decoder

Interface
REQ-001 Parameter: CNT_W, default 8, width of the saturating error counter.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream asserts that in_gray holds a code word.
REQ-005 Port: in_gray  input  4  Gray-coded word, bit 3 MSB, as produced by the upstream Gray encoder.
REQ-006 Port: in_ready  output  1  block can accept a word this cycle.
REQ-007 Port: out_valid  output  1  out_bin and step_err hold a decoded result.
REQ-008 Port: out_bin  output  4  binary value decoded from the accepted word.
REQ-009 Port: step_err  output  1  accepted word violated the sequence rule; qualified by out_valid.
REQ-010 Port: out_ready  input  1  downstream accepts the result this cycle.
REQ-011 Port: err_count  output  CNT_W  saturating count of accepted words with step_err set.

Function
REQ-012 An input transfer SHALL occur when in_valid and in_ready are both 1 at a rising clk edge; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-013 in_ready SHALL equal (!out_valid || out_ready), combinationally, so that simultaneous output and input transfers give full throughput.
REQ-014 Decode: b[3]=g[3], b[i]=b[i+1]^g[i] for i=2..0; the result SHALL be registered into out_bin one cycle after the input transfer (latency 1).
REQ-015 out_valid SHALL set on an input transfer, clear on an output transfer with no simultaneous input transfer, and stay set when both occur.
REQ-016 out_bin and step_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 The tracker SHALL be a two-state machine: FIRST (no previous word) and TRACK; FIRST goes to TRACK on any input transfer; TRACK has no exit except reset.
REQ-018 In FIRST, the accepted word SHALL produce step_err=0 and be stored as the previous word.
REQ-019 In TRACK, step_err SHALL be 1 when the Hamming distance between in_gray and the previous word is 2 or more; distance 0 (repeat) and distance 1 SHALL give step_err=0.
REQ-020 Every accepted word, erroneous or not, SHALL replace the previous word.
REQ-021 err_count SHALL increment by 1 on each input transfer that yields step_err=1 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-022 With in_valid=0 no internal state other than out_valid SHALL change.

Reset
REQ-023 While rst=1, out_valid=0, out_bin=0, step_err=0, err_count=0, previous word=0, and state=FIRST, independent of clk.
REQ-024 Reset asserted mid-stream SHALL discard any pending output; the first word after reset release SHALL be treated as a FIRST word.
REQ-025 in_ready SHALL be 1 during and immediately after reset.

Configuration
REQ-026 Macro GRAY_DIR_CHECK_EN: when defined, step_err in TRACK SHALL also be 1 when the decoded value is neither the previous binary value nor the previous binary value+1 mod 16, so 15->0 is legal and a backward step is an error.
REQ-027 Without GRAY_DIR_CHECK_EN, only the Hamming-distance rule SHALL apply, so a single-bit backward step gives step_err=0.

Verification
REQ-028 Reset, then in_gray=4'b1100 with in_valid=1 and out_ready=1 -> next cycle out_valid=1, out_bin=4'b1000, step_err=0.
REQ-029 Stream Gray codes 0000,0001,0011,0010 back-to-back with out_ready=1 -> out_bin 0,1,2,3 on consecutive cycles, in_ready constantly 1, err_count=0.
REQ-030 After 0000, send 0011 -> step_err=1, err_count=1; then send 0010 -> step_err=0.
REQ-031 Hold out_ready=0 with one result pending -> in_ready=0, out_bin stable; release -> the held result transfers, then the next word is accepted.
REQ-032 Inject 300 consecutive two-bit jumps with CNT_W=8 -> err_count stops at 255; assert rst mid-stream -> all outputs 0 at once, and the next word gives step_err=0.
REQ-033 With GRAY_DIR_CHECK_EN: 1000 (15) then 0000 (0) -> step_err=0; 0001 (1) then 0000 (0) -> step_err=1; without the macro, the second case gives step_err=0.

Source files
------------

// File: rtl/gray_stream_decoder.sv
// Decodes a stream of 4-bit Gray words to binary through a one-deep valid/ready stage.
// It flags sequence-step violations and saturates an error count; GRAY_DIR_CHECK_EN adds a forward-only step check.
module gray_stream_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       in_gray,
    output logic             in_ready,
    output logic             out_valid,
    output logic [3:0]       out_bin,
    output logic             step_err,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic {
        ST_FIRST,
        ST_TRACK
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic [3:0]       out_bin_q, out_bin_d;
    logic             step_err_q, step_err_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             accept;
    logic             xfer_out;
    logic [3:0]       dec_bin;
    logic [3:0]       diff;
    logic             ham_err;
    logic             dir_err;
    logic             word_err;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign xfer_out = out_valid_q && out_ready;

    assign dec_bin = gray2bin(in_gray);
    assign diff    = in_gray ^ prev_q;
    // Two or more differing bits: clearing the lowest set bit leaves something.
    assign ham_err = |(diff & (diff - 4'd1));

`ifdef GRAY_DIR_CHECK_EN
    logic [3:0] prev_bin;
    logic [3:0] prev_bin_inc;
    assign prev_bin     = gray2bin(prev_q);
    assign prev_bin_inc = prev_bin + 4'd1;
    assign dir_err      = (dec_bin != prev_bin) && (dec_bin != prev_bin_inc);
`else
    assign dir_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        word_err = 1'b0;
        unique case (state_q)
            ST_FIRST: begin
                word_err = 1'b0;
                if (accept) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                word_err = ham_err || dir_err;
            end
            default: begin
                state_d = ST_FIRST;
            end
        endcase
    end

    always_comb begin
        prev_d      = prev_q;
        out_bin_d   = out_bin_q;
        step_err_d  = step_err_q;
        out_valid_d = out_valid_q;
        err_cnt_d   = err_cnt_q;
        if (accept) begin
            prev_d      = in_gray;
            out_bin_d   = dec_bin;
            step_err_d  = word_err;
            out_valid_d = 1'b1;
            if (word_err && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (xfer_out) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FIRST;
            prev_q      <= 4'd0;
            out_bin_q   <= 4'd0;
            step_err_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            out_bin_q   <= out_bin_d;
            step_err_q  <= step_err_d;
            out_valid_q <= out_valid_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign step_err  = step_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Directed bench for gray_stream_decoder with a result scoreboard.
// Inputs change on the falling edge; checks are made 1ns later.
module tb_gray_stream_decoder;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [3:0]       in_gray;
    logic             in_ready;
    logic             out_valid;
    logic [3:0]       out_bin;
    logic             step_err;
    logic             out_ready;
    logic [CNT_W-1:0] err_count;

    typedef struct packed {
        logic [3:0] bin;
        logic       err;
    } exp_t;

    exp_t             sb[$];
    int               total = 0;
    int               bad = 0;

    logic             m_first;
    logic [3:0]       m_prev;
    logic             m_ov;
    logic [CNT_W-1:0] m_cnt;

    gray_stream_decoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_gray   (in_gray),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bin   (out_bin),
        .step_err  (step_err),
        .out_ready (out_ready),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_dec(input logic [3:0] g);
        logic [3:0] b;
        b = 4'd0;
        for (int k = 3; k >= 0; k--) begin
            b[k] = g[k] ^ ((k == 3) ? 1'b0 : b[k+1]);
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_first = 1'b1;
        m_prev  = 4'd0;
        m_ov    = 1'b0;
        m_cnt   = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ov"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_bin"}, {28'd0, out_bin}, 32'd0);
        chk({tag, "_err"}, {31'd0, step_err}, 32'd0);
        chk({tag, "_cnt"}, 32'(err_count), 32'd0);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic cyc(input logic v, input logic [3:0] g, input logic ordy);
        exp_t       e;
        logic       acc;
        logic       oxf;
        logic [3:0] nb;
        logic [3:0] pb;
        logic [3:0] pb1;
        in_valid  = v;
        in_gray   = g;
        out_ready = ordy;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_ov || ordy)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (m_ov) begin
            e = sb[0];
            chk("out_bin", {28'd0, out_bin}, {28'd0, e.bin});
            chk("step_err", {31'd0, step_err}, {31'd0, e.err});
        end
        acc = v && (!m_ov || ordy);
        oxf = m_ov && ordy;
        if (oxf) void'(sb.pop_front());
        if (acc) begin
            nb  = ref_dec(g);
            pb  = ref_dec(m_prev);
            pb1 = pb + 4'd1;
            e.bin = nb;
            e.err = 1'b0;
            if (!m_first) begin
                e.err = ($countones(g ^ m_prev) >= 2);
`ifdef GRAY_DIR_CHECK_EN
                if (nb != pb && nb != pb1) e.err = 1'b1;
`endif
            end
            if (e.err && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
            m_first = 1'b0;
            m_prev  = g;
            sb.push_back(e);
        end
        m_ov = acc ? 1'b1 : (oxf ? 1'b0 : m_ov);
        @(posedge clk);
        #1;
        chk("err_count", 32'(err_count), 32'(m_cnt));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        chk_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_gray   = 4'd0;
        out_ready = 1'b0;
        model_clear();
        #3;
        chk_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // 1100 decodes to 1000 with latency 1
        cyc(1'b1, 4'b1100, 1'b1);
        chk("dec_1100", {28'd0, out_bin}, 32'h8);
        cyc(1'b0, 4'b0000, 1'b1);

        // back-to-back counting stream
        do_reset();
        cyc(1'b1, 4'b0000, 1'b1);
        cyc(1'b1, 4'b0001, 1'b1);
        cyc(1'b1, 4'b0011, 1'b1);
        cyc(1'b1, 4'b0010, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1);
        chk("stream_cnt", 32'(err_count), 32'd0);

        // two-bit jump then a legal single-bit step
        do_reset();
        cyc(1'b1, 4'b0000, 1'b1);
        cyc(1'b1, 4'b0011, 1'b1);
        chk("jump_err", {31'd0, step_err}, 32'd1);
        cyc(1'b1, 4'b0010, 1'b1);
        chk("legal_err", {31'd0, step_err}, 32'd0);
        cyc(1'b1, 4'b0010, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1);

        // backpressure: result held, input stalled
        do_reset();
        cyc(1'b1, 4'b0000, 1'b1);
        cyc(1'b1, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0001, 1'b0);
        chk("stall_rdy", {31'd0, in_ready}, 32'd0);
        cyc(1'b1, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0001, 1'b1);
        cyc(1'b0, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0000, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1);

        // wrap and backward steps
        do_reset();
        cyc(1'b1, 4'b1000, 1'b1);
        cyc(1'b1, 4'b0000, 1'b1);
        cyc(1'b1, 4'b0001, 1'b1);
        cyc(1'b1, 4'b0000, 1'b1);
        cyc(1'b0, 4'b0000, 1'b1);

        // saturation then async reset mid-stream
        do_reset();
        for (int i = 0; i < 301; i++) begin
            cyc(1'b1, (i % 2 == 0) ? 4'b0000 : 4'b0011, 1'b1);
        end
        chk("sat_cnt", 32'(err_count), 32'd255);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 4'b0011, 1'b1);
        chk("first_after_rst", {31'd0, step_err}, 32'd0);
        cyc(1'b0, 4'b0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
